// File: rtl/pwm_timer_controller_if.sv
// Bus-side port bundle for the PWM timer controller.
// Master drives address/data/strobes; slave returns rdata/ack.
interface pwm_timer_controller_if #(
    parameter int N = 64
);
    logic [31:0]  address;
    logic [N-1:0] wdata;
    logic [N-1:0] rdata;
    logic         mem_write;
    logic         mem_read;
    logic [1:0]   size;
    logic         ack;

    modport master (
        output address, wdata, mem_write, mem_read, size,
        input  rdata, ack
    );

    modport slave (
        input  address, wdata, mem_write, mem_read, size,
        output rdata, ack
    );
endinterface

// File: rtl/pwm_timer_controller.sv
// Memory-mapped bank of PWM timers with double-buffered period/duty,
// one-shot/reload sequencing and an aggregated wrap interrupt.
module pwm_timer_controller #(
    parameter int          N             = 64,
    parameter int          CHANNELS      = 4,
    parameter int          CW            = 16,
    parameter logic [31:0] BASE_ADDRESS  = 32'h0900_0000,
    parameter int          ADDRESS_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    pwm_timer_controller_if.slave  bus,
    output logic [CHANNELS-1:0]    pwm_out,
    output logic                   irq
);
    localparam logic [31:0] MASK = ~(32'hFFFF_FFFF << ADDRESS_WIDTH);

    logic [31:0]         off;
    logic                hit, wr, rd;
    logic                chan_hit, status_hit;
    logic [2:0]          ch_sel;
    logic [1:0]          reg_sel;
    logic [N-1:0]        wm, rd_val, rdata_q;
    logic [CW-1:0]       wv;
    logic                ack_q;
    logic                unused_wm;

    logic [CHANNELS-1:0] en, os, inv, ie, status;
    logic [CHANNELS-1:0] tcon_w, per_w, duty_w, start, wrap, clr;
    logic [CW-1:0]       count      [CHANNELS];
    logic [CW-1:0]       period_buf [CHANNELS];
    logic [CW-1:0]       duty_buf   [CHANNELS];
    logic [CW-1:0]       period_act [CHANNELS];
    logic [CW-1:0]       duty_act   [CHANNELS];

    assign off        = bus.address & MASK;
    assign hit        = (bus.address & ~MASK) == BASE_ADDRESS;
    assign wr         = hit & bus.mem_write;
    assign rd         = hit & bus.mem_read & ~bus.mem_write;
    assign ch_sel     = off[7:5];
    assign reg_sel    = off[4:3];
    assign chan_hit   = (off[31:8] == 24'd0) && (off[2:0] == 3'd0)
                      && (int'(ch_sel) < CHANNELS);
    assign status_hit = off == 32'h0000_00F0;

    always_comb begin
        wm = '0;
        unique case (bus.size)
            2'b00:   wm = N'(bus.wdata[7:0]);
            2'b01:   wm = N'(bus.wdata[15:0]);
            2'b10:   wm = N'(bus.wdata[31:0]);
            default: wm = bus.wdata;
        endcase
    end

    assign wv        = wm[CW-1:0];
    assign unused_wm = ^wm;
    assign clr       = (wr && status_hit) ? wm[CHANNELS-1:0] : '0;

    // A start (EN rising or RELOAD) pre-empts a wrap on the same edge.
    always_comb begin
        tcon_w = '0;
        per_w  = '0;
        duty_w = '0;
        start  = '0;
        wrap   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr && chan_hit && int'(ch_sel) == c) begin
                tcon_w[c] = reg_sel == 2'd0;
                per_w[c]  = reg_sel == 2'd1;
                duty_w[c] = reg_sel == 2'd2;
            end
            start[c] = tcon_w[c] && ((wm[0] && !en[c]) || wm[3]);
            wrap[c]  = en[c] && (count[c] == period_act[c]) && !start[c];
        end
    end

    always_comb begin
        rd_val = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (chan_hit && int'(ch_sel) == c) begin
                unique case (reg_sel)
                    2'd0: rd_val = N'({ie[c], 1'b0, inv[c], os[c], en[c]});
                    2'd1: rd_val = N'(period_buf[c]);
                    2'd2: rd_val = N'(duty_buf[c]);
                    2'd3: rd_val = N'(count[c]);
                endcase
            end
        end
        if (status_hit)
            rd_val = N'(status);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rdata_q <= '0;
            ack_q   <= 1'b0;
            en      <= '0;
            os      <= '0;
            inv     <= '0;
            ie      <= '0;
            status  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                count[c]      <= '0;
                period_buf[c] <= '0;
                duty_buf[c]   <= '0;
                period_act[c] <= '0;
                duty_act[c]   <= '0;
            end
        end else begin
            ack_q <= wr | rd;
            if (wr)
                rdata_q <= '0;
            else if (rd)
                rdata_q <= rd_val;
            status <= (status & ~clr) | wrap;
            for (int c = 0; c < CHANNELS; c++) begin
                if (tcon_w[c]) begin
                    en[c]  <= wm[0];
                    os[c]  <= wm[1];
                    inv[c] <= wm[2];
                    ie[c]  <= wm[4];
                end
                if (per_w[c])
                    period_buf[c] <= wv;
                if (duty_w[c])
                    duty_buf[c] <= wv;
                if (start[c]) begin
                    count[c]      <= '0;
                    period_act[c] <= period_buf[c];
                    duty_act[c]   <= duty_buf[c];
                end else if (wrap[c]) begin
                    count[c]      <= '0;
                    period_act[c] <= period_buf[c];
                    duty_act[c]   <= duty_buf[c];
                    if (os[c])
                        en[c] <= 1'b0;
                end else if (en[c]) begin
                    count[c] <= count[c] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        pwm_out = '0;
        for (int c = 0; c < CHANNELS; c++)
            pwm_out[c] = en[c] ? ((count[c] < duty_act[c]) ^ inv[c]) : inv[c];
    end

    assign irq       = |(status & ie);
    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
endmodule

// File: tb/tb_pwm_timer_controller.sv
// Directed bench for pwm_timer_controller: bus map, waveform shape,
// one-shot/IRQ, width rules, window decode and reset.
module tb_pwm_timer_controller;
    localparam logic [31:0] B = 32'h0900_0000;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] pwm_out;
    logic       irq;
    int         checks = 0;
    int         errors = 0;

    pwm_timer_controller_if #(.N(64)) bus ();

    pwm_timer_controller #(
        .N(64), .CHANNELS(4), .CW(16),
        .BASE_ADDRESS(B), .ADDRESS_WIDTH(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .pwm_out(pwm_out),
        .irq(irq)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One bus cycle: strobes sampled at the next edge, returns #1 after it.
    task automatic access(input logic [31:0] a, input logic [63:0] d,
                          input logic [1:0] s, input logic r, input logic w);
        @(negedge clock);
        bus.address   = a;
        bus.wdata     = d;
        bus.size      = s;
        bus.mem_read  = r;
        bus.mem_write = w;
        @(posedge clock);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [63:0] d,
                          input logic [1:0] s);
        access(a, d, s, 1'b0, 1'b1);
        chk("ack_w", 64'(bus.ack), 64'd1);
    endtask

    task automatic rd_reg(input string tag, input logic [31:0] a,
                          input logic [63:0] exp);
        access(a, 64'd0, 2'b11, 1'b1, 1'b0);
        chk({tag, "_ack"}, 64'(bus.ack), 64'd1);
        chk(tag, bus.rdata, exp);
    endtask

    initial begin
        bus.address   = 32'd0;
        bus.wdata     = 64'd0;
        bus.size      = 2'b11;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;

        tick();
        tick();
        chk("rst_ack", 64'(bus.ack), 64'd0);
        chk("rst_rdata", bus.rdata, 64'd0);
        chk("rst_pwm", 64'(pwm_out), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        reset = 1'b1;

        // ch0: period 9, duty 3 -> 3 high / 7 low
        wr_reg(B + 32'h08, 64'd9, 2'b11);
        tick();
        chk("ack_drop", 64'(bus.ack), 64'd0);
        wr_reg(B + 32'h10, 64'd3, 2'b11);
        wr_reg(B + 32'h00, 64'h01, 2'b11);
        for (int k = 0; k < 20; k++) begin
            chk("pwm0_d3", 64'(pwm_out[0]), 64'((k % 10) < 3));
            tick();
        end
        rd_reg("status_wrap", B + 32'hF0, 64'h1);
        chk("irq_no_ie", 64'(irq), 64'd0);

        // duty change mid-period lands after the next wrap
        wr_reg(B + 32'h10, 64'd7, 2'b11);
        rd_reg("duty_buf", B + 32'h10, 64'd7);
        for (int j = 0; j < 17; j++) begin
            chk("pwm0_dchg", 64'(pwm_out[0]),
                64'((j < 7) ? 1'b0 : ((j - 7) < 7)));
            tick();
        end

        // one-shot with IE
        wr_reg(B + 32'h00, 64'h00, 2'b11);
        wr_reg(B + 32'hF0, 64'hF, 2'b11);
        wr_reg(B + 32'h08, 64'd4, 2'b11);
        wr_reg(B + 32'h00, 64'h13, 2'b11);
        for (int k = 0; k < 5; k++) begin
            chk("os_pwm", 64'(pwm_out[0]), 64'd1);
            chk("os_irq_lo", 64'(irq), 64'd0);
            tick();
        end
        chk("os_irq_hi", 64'(irq), 64'd1);
        chk("os_idle", 64'(pwm_out[0]), 64'd0);
        rd_reg("os_tcon", B + 32'h00, 64'h12);
        rd_reg("os_count", B + 32'h18, 64'h0);
        wr_reg(B + 32'hF0, 64'h1, 2'b11);
        chk("w1c_irq", 64'(irq), 64'd0);

        // wrap and W1C on the same edge: set wins
        wr_reg(B + 32'h00, 64'h13, 2'b11);
        repeat (4) tick();
        wr_reg(B + 32'hF0, 64'h1, 2'b11);
        chk("setwin_irq", 64'(irq), 64'd1);
        rd_reg("setwin_st", B + 32'hF0, 64'h1);
        wr_reg(B + 32'hF0, 64'hF, 2'b11);
        chk("clr_irq", 64'(irq), 64'd0);

        // EN=0 written on the one-shot wrap edge: flag still set
        wr_reg(B + 32'h00, 64'h13, 2'b11);
        repeat (4) tick();
        wr_reg(B + 32'h00, 64'h12, 2'b11);
        rd_reg("en0wrap_st", B + 32'hF0, 64'h1);
        rd_reg("en0wrap_tc", B + 32'h00, 64'h12);
        wr_reg(B + 32'hF0, 64'hF, 2'b11);

        // width rules and window decode
        wr_reg(B + 32'h08, 64'hABCD, 2'b00);
        rd_reg("byte_wr", B + 32'h08, 64'hCD);
        wr_reg(B + 32'h10, 64'h1_2345, 2'b01);
        rd_reg("half_wr", B + 32'h10, 64'h2345);
        wr_reg(B + 32'h08, 64'hFFFF_FFFF_1234_5678, 2'b10);
        rd_reg("word_wr", B + 32'h08, 64'h5678);
        wr_reg(B + 32'hE0, 64'hFFFF, 2'b11);
        rd_reg("unmapped", B + 32'hE0, 64'h0);
        rd_reg("pre_miss", B + 32'h08, 64'h5678);
        access(B + 32'h100, 64'd0, 2'b11, 1'b1, 1'b0);
        chk("miss_ack", 64'(bus.ack), 64'd0);
        chk("miss_rdata", bus.rdata, 64'h5678);
        access(B + 32'h108, 64'h1111, 2'b11, 1'b0, 1'b1);
        chk("miss_wack", 64'(bus.ack), 64'd0);
        rd_reg("miss_nowr", B + 32'h08, 64'h5678);

        // ch1: INV idle, then duty > period
        wr_reg(B + 32'h20, 64'h04, 2'b11);
        chk("inv_idle", 64'(pwm_out[1]), 64'd1);
        wr_reg(B + 32'h28, 64'd9, 2'b11);
        wr_reg(B + 32'h30, 64'd20, 2'b11);
        wr_reg(B + 32'h20, 64'h01, 2'b11);
        for (int k = 0; k < 12; k++) begin
            chk("duty_gt_per", 64'(pwm_out[1]), 64'd1);
            tick();
        end

        // ch2: period 0 wraps every cycle
        wr_reg(B + 32'h48, 64'd0, 2'b11);
        wr_reg(B + 32'h50, 64'd1, 2'b11);
        wr_reg(B + 32'h40, 64'h01, 2'b11);
        for (int k = 0; k < 4; k++) begin
            chk("per0_pwm", 64'(pwm_out[2]), 64'd1);
            tick();
        end
        rd_reg("per0_count", B + 32'h58, 64'h0);
        wr_reg(B + 32'hF0, 64'h4, 2'b11);
        access(B + 32'hF0, 64'd0, 2'b11, 1'b1, 1'b0);
        chk("per0_flag", 64'(bus.rdata[2]), 64'd1);

        // ch3: duty 0 is constant inactive
        wr_reg(B + 32'h68, 64'd5, 2'b11);
        wr_reg(B + 32'h70, 64'd0, 2'b11);
        wr_reg(B + 32'h60, 64'h01, 2'b11);
        for (int k = 0; k < 8; k++) begin
            chk("duty0_pwm", 64'(pwm_out[3]), 64'd0);
            tick();
        end
        chk("irq_off", 64'(irq), 64'd0);

        // mid-period reset with all channels enabled
        wr_reg(B + 32'h00, 64'h01, 2'b11);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("mrst_pwm", 64'(pwm_out), 64'd0);
        chk("mrst_irq", 64'(irq), 64'd0);
        chk("mrst_ack", 64'(bus.ack), 64'd0);
        chk("mrst_rdata", bus.rdata, 64'd0);
        reset = 1'b1;
        rd_reg("mrst_count", B + 32'h18, 64'h0);
        rd_reg("mrst_status", B + 32'hF0, 64'h0);
        rd_reg("mrst_tcon", B + 32'h00, 64'h0);

        // read and write together: write wins, rdata 0
        wr_reg(B + 32'h08, 64'h33, 2'b11);
        rd_reg("rw_pre", B + 32'h08, 64'h33);
        access(B + 32'h10, 64'h55, 2'b11, 1'b1, 1'b1);
        chk("rw_ack", 64'(bus.ack), 64'd1);
        chk("rw_rdata", bus.rdata, 64'd0);
        rd_reg("rw_commit", B + 32'h10, 64'h55);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
